// File: rtl/etcpu_boot_ctrl.sv
// etcpu_boot_ctrl: boot sequencer. Streams a program into instruction memory
// over a valid/ready handshake, holds the CPU in reset while loading and for
// HOLD_CYC cycles afterwards, then releases it.
// Optional feature macro: ETCPU_BOOT_CKSUM_EN. When it is defined, the block
// compares a modulo sum of the loaded words against exp_cksum before releasing
// the CPU.
//
// state | meaning
// IDLE  | no image loaded, or the last boot failed; CPU held in reset
// LOAD  | accepting words and writing them to instruction memory
// HOLD  | load complete; settle countdown with CPU still in reset
// RUN   | CPU released; a new boot_start reloads
module etcpu_boot_ctrl #(
  parameter int DAT_W    = 32,
  parameter int ADD_W    = 32,
  parameter int DEPTH    = 32,
  parameter int HOLD_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             boot_start,
  input  logic [ADD_W-1:0] prog_len,
  input  logic             ld_vld,
  input  logic [DAT_W-1:0] ld_dat,
`ifdef ETCPU_BOOT_CKSUM_EN
  input  logic [DAT_W-1:0] exp_cksum,
  output logic             cksum_err,
`endif
  output logic             ld_rdy,
  output logic             inst_mem_wr_wen,
  output logic [ADD_W-1:0] inst_mem_wr_addr,
  output logic [DAT_W-1:0] inst_mem_wr_dat,
  output logic             rst_n_cpu,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int HC_W = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [ADD_W-1:0] cnt;
  logic [ADD_W-1:0] len_q;
  logic [HC_W-1:0]  hold_cnt;
  logic             start_ok, len_ok, accept_good, accept_bad;
  logic             hs, last_hs, hold_end, cksum_bad;

`ifdef ETCPU_BOOT_CKSUM_EN
  logic [DAT_W-1:0] sum;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Handshake/acceptance decode and next-state logic
  always_comb begin
    state_nxt   = state;
    ld_rdy      = (state == S_LOAD);
    start_ok    = boot_start && ((state == S_IDLE) || (state == S_RUN));
    len_ok      = (prog_len != '0) && (prog_len <= ADD_W'(DEPTH));
    accept_good = start_ok && len_ok;
    accept_bad  = start_ok && !len_ok;
    hs          = ld_rdy && ld_vld;
    last_hs     = hs && (cnt == len_q - ADD_W'(1));
    hold_end    = (state == S_HOLD) && (hold_cnt == HC_W'(1));
`ifdef ETCPU_BOOT_CKSUM_EN
    cksum_bad   = hold_end && (sum != exp_cksum);
`else
    cksum_bad   = 1'b0;
`endif
    case (state)
      S_IDLE, S_RUN: begin
        if (accept_good)     state_nxt = S_LOAD;
        else if (accept_bad) state_nxt = S_IDLE;
      end
      S_LOAD: if (last_hs) state_nxt = S_HOLD;
      S_HOLD: if (hold_end) state_nxt = cksum_bad ? S_IDLE : S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs; busy/rst_n_cpu follow the state being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy             <= 1'b0;
      rst_n_cpu        <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      inst_mem_wr_wen  <= 1'b0;
      inst_mem_wr_addr <= '0;
      inst_mem_wr_dat  <= '0;
    end else begin
      busy            <= (state_nxt == S_LOAD) || (state_nxt == S_HOLD);
      rst_n_cpu       <= (state_nxt == S_RUN);
      done            <= (state == S_HOLD) && (state_nxt == S_RUN);
      inst_mem_wr_wen <= hs;
      if (hs) begin
        inst_mem_wr_addr <= cnt;
        inst_mem_wr_dat  <= ld_dat;
      end
      if (accept_bad)       err <= 1'b1;
      else if (accept_good) err <= 1'b0;
    end
  end

  // Word counter, latched length and settle down-counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      len_q    <= '0;
      hold_cnt <= '0;
    end else begin
      if (accept_good) begin
        cnt   <= '0;
        len_q <= prog_len;
      end else if (hs) begin
        cnt <= cnt + ADD_W'(1);
      end
      if (last_hs)               hold_cnt <= HC_W'(HOLD_CYC);
      else if (state == S_HOLD)  hold_cnt <= hold_cnt - HC_W'(1);
    end
  end

`ifdef ETCPU_BOOT_CKSUM_EN
  // Running sum of accepted words and sticky mismatch flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      cksum_err <= 1'b0;
    end else begin
      if (accept_good) sum <= '0;
      else if (hs)     sum <= sum + ld_dat;
      if (cksum_bad)   cksum_err <= 1'b1;
    end
  end
`endif

endmodule
